// File: rtl/mapper_flash_banked_if.sv
// Slot-side bus of the banked flash mapper: CPU strobes in, storage
// requests and the CPU read-back byte out.
//
// Handshake semantics: cpu_wr / cpu_rd are single-cycle strobes that are
// qualified by cs and accepted in the cycle they are high (no ready, the
// mapper never stalls). prog_we is a single-cycle valid pulse with no ready.
// erase_req is a level request that stays high until the storage returns a
// single-cycle erase_done, and falls the cycle after that pulse.
interface mapper_flash_banked_if #(
    parameter int ADDR_W = 27
);
    logic              cs;
    logic [15:0]       cpu_addr;
    logic [7:0]        cpu_data;
    logic              cpu_wr;
    logic              cpu_rd;
    logic              ram_cs;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
    logic              data_oe;
    logic              prog_we;
    logic [7:0]        prog_data;
    logic              erase_req;
    logic              erase_chip;
    logic              erase_done;
    logic [3:0]        state_dbg;

    modport slave (
        input  cs, cpu_addr, cpu_data, cpu_wr, cpu_rd, erase_done,
        output ram_cs, addr, data, data_oe, prog_we, prog_data,
               erase_req, erase_chip, state_dbg
    );

    modport master (
        output cs, cpu_addr, cpu_data, cpu_wr, cpu_rd, erase_done,
        input  ram_cs, addr, data, data_oe, prog_we, prog_data,
               erase_req, erase_chip, state_dbg
    );
endinterface

// File: rtl/mapper_flash_banked.sv
// Bank-switching cartridge mapper with AMD/JEDEC flash command emulation.
// NUM_WIN 8 KB windows from 0x4000 map onto banks; the command FSM decodes
// unlock/program/erase/autoselect and returns status or ID bytes.
module mapper_flash_banked #(
    parameter int          NUM_WIN     = 4,
    parameter int          BANK_BITS   = 8,
    parameter int          ADDR_W      = 27,
    parameter int          PROG_CYCLES = 16,
    parameter logic [7:0]  MANUF_ID    = 8'h01,
    parameter logic [7:0]  DEVICE_ID   = 8'hA4
) (
    input  logic clk,
    input  logic reset_n,
    mapper_flash_banked_if.slave bus
);
    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_U1    = 4'd1;
    localparam logic [3:0] S_U2    = 4'd2;
    localparam logic [3:0] S_PROG  = 4'd3;
    localparam logic [3:0] S_AUTO  = 4'd4;
    localparam logic [3:0] S_E0    = 4'd5;
    localparam logic [3:0] S_E1    = 4'd6;
    localparam logic [3:0] S_E2    = 4'd7;
    localparam logic [3:0] S_BUSY  = 4'd8;
    localparam logic [3:0] S_ERASE = 4'd9;

    localparam int              CNT_W    = $clog2(PROG_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PROG_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [3:0]           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BANK_BITS-1:0] bank_q [NUM_WIN];
    logic                 prog_we_q, prog_we_d;
    logic [7:0]           prog_data_q, prog_data_d;
    logic [ADDR_W-1:0]    prog_addr_q, prog_addr_d;
    logic                 erase_chip_q, erase_chip_d;
    logic [BANK_BITS-1:0] erase_bank_q, erase_bank_d;
    logic                 toggle_q, toggle_d;
    logic                 bank_wr;

    logic [2:0]           win_raw;
    logic [1:0]           win;
    logic                 hit;
    logic [12:0]          off;
    logic [11:0]          a12;
    logic                 wr, rd;
    logic [BANK_BITS-1:0] sel_bank;
    logic [ADDR_W-1:0]    map_addr;
    logic                 status, id_rd;

    // Window decode and the mapped storage address for the current CPU cycle
    always_comb begin
        win_raw  = bus.cpu_addr[15:13] - 3'd2;
        win      = win_raw[1:0];
        hit      = bus.cs && (bus.cpu_addr[15:14] != 2'b00) && (win_raw < 3'(NUM_WIN));
        off      = bus.cpu_addr[12:0];
        a12      = off[11:0];
        wr       = hit && bus.cpu_wr;
        rd       = hit && bus.cpu_rd;
        sel_bank = bank_q[0];
        for (int i = 0; i < NUM_WIN; i++) begin
            if (win == 2'(i)) sel_bank = bank_q[i];
        end
        map_addr = ADDR_W'({sel_bank, off});
    end

    // Command FSM, busy counter and latched program/erase parameters
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        prog_we_d    = 1'b0;
        prog_data_d  = prog_data_q;
        prog_addr_d  = prog_addr_q;
        erase_chip_d = erase_chip_q;
        erase_bank_d = erase_bank_q;
        bank_wr      = 1'b0;
        toggle_d     = toggle_q ^ (status && rd);
        if (state_q == S_BUSY) begin
            if (cnt_q <= CNT_ONE) begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q - CNT_ONE;
            end
        end else if (state_q == S_ERASE) begin
            // erase_done takes priority; any concurrent write is dropped
            if (bus.erase_done) begin
                state_d      = S_IDLE;
                erase_chip_d = 1'b0;
            end
        end else if (wr) begin
            if (state_q == S_IDLE && off[12:11] == 2'b10) begin
                bank_wr = 1'b1;
            end else if (bus.cpu_data == 8'hF0) begin
                state_d = S_IDLE;
            end else begin
                case (state_q)
                    S_IDLE: if (bus.cpu_data == 8'hAA && a12 == 12'hAAA) state_d = S_U1;
                    S_U1:   state_d = (bus.cpu_data == 8'h55 && a12 == 12'h555) ? S_U2 : S_IDLE;
                    S_U2: begin
                        state_d = S_IDLE;
                        if (a12 == 12'hAAA) begin
                            if (bus.cpu_data == 8'hA0) state_d = S_PROG;
                            else if (bus.cpu_data == 8'h90) state_d = S_AUTO;
                            else if (bus.cpu_data == 8'h80) state_d = S_E0;
                        end
                    end
                    S_E0:   state_d = (bus.cpu_data == 8'hAA && a12 == 12'hAAA) ? S_E1 : S_IDLE;
                    S_E1:   state_d = (bus.cpu_data == 8'h55 && a12 == 12'h555) ? S_E2 : S_IDLE;
                    S_E2: begin
                        state_d = S_IDLE;
                        if (bus.cpu_data == 8'h30) begin
                            state_d      = S_ERASE;
                            erase_chip_d = 1'b0;
                            erase_bank_d = sel_bank;
                        end else if (bus.cpu_data == 8'h10 && a12 == 12'hAAA) begin
                            state_d      = S_ERASE;
                            erase_chip_d = 1'b1;
                            erase_bank_d = sel_bank;
                        end
                    end
                    S_PROG: begin
                        prog_we_d   = 1'b1;
                        prog_data_d = bus.cpu_data;
                        prog_addr_d = map_addr;
                        cnt_d       = CNT_LOAD;
                        state_d     = S_BUSY;
                    end
                    S_AUTO:  state_d = S_AUTO;
                    default: state_d = S_IDLE;
                endcase
            end
        end
    end

    // State, bank registers and latched request data
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            prog_we_q    <= 1'b0;
            prog_data_q  <= '0;
            prog_addr_q  <= '0;
            erase_chip_q <= 1'b0;
            erase_bank_q <= '0;
            toggle_q     <= 1'b0;
            for (int i = 0; i < NUM_WIN; i++) bank_q[i] <= BANK_BITS'(i);
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            prog_we_q    <= prog_we_d;
            prog_data_q  <= prog_data_d;
            prog_addr_q  <= prog_addr_d;
            erase_chip_q <= erase_chip_d;
            erase_bank_q <= erase_bank_d;
            toggle_q     <= toggle_d;
            for (int i = 0; i < NUM_WIN; i++) begin
                if (bank_wr && win == 2'(i)) bank_q[i] <= bus.cpu_data[BANK_BITS-1:0];
            end
        end
    end

    // CPU read-back mux and storage-side outputs; the latched program or
    // erase address overrides the live mapping while that request is active
    always_comb begin
        status        = (state_q == S_BUSY) || (state_q == S_ERASE);
        id_rd         = (state_q == S_AUTO) && rd && (off[12:1] == 12'd0);
        bus.data_oe   = status || id_rd;
        bus.ram_cs    = rd && !bus.data_oe;
        if (state_q == S_BUSY)       bus.data = {~prog_data_q[7], toggle_q, 6'b0};
        else if (state_q == S_ERASE) bus.data = {1'b0, toggle_q, 6'b0};
        else if (id_rd)              bus.data = off[0] ? DEVICE_ID : MANUF_ID;
        else                         bus.data = 8'hFF;
        if (prog_we_q)               bus.addr = prog_addr_q;
        else if (state_q == S_ERASE) bus.addr = ADDR_W'({erase_bank_q, 13'd0});
        else if (hit)                bus.addr = map_addr;
        else                         bus.addr = '1;
        bus.prog_we    = prog_we_q;
        bus.prog_data  = prog_data_q;
        bus.erase_req  = (state_q == S_ERASE);
        bus.erase_chip = erase_chip_q;
        bus.state_dbg  = state_q;
    end
endmodule

// File: tb/tb_mapper_flash_banked.sv
// Directed bench for mapper_flash_banked: stimulus pushes expected responses,
// a negedge monitor pops and compares reads, program pulses and erase requests.
module tb_mapper_flash_banked;
    logic clk = 1'b0;
    logic reset_n;
    int   n_pass  = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    mapper_flash_banked_if #(.ADDR_W(27)) bus ();

    mapper_flash_banked #(
        .NUM_WIN(4), .BANK_BITS(8), .ADDR_W(27), .PROG_CYCLES(16),
        .MANUF_ID(8'h01), .DEVICE_ID(8'hA4)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    // read record: {prog_we, erase_req, erase_chip, ram_cs, data_oe, data, addr}
    logic [39:0] exp_q[$];
    string       name_q[$];
    logic [34:0] prog_q[$];   // {addr, prog_data}
    logic [28:0] erase_q[$];  // {check_addr, erase_chip, addr}
    logic        er_prev   = 1'b0;
    logic        done_prev = 1'b0;

    function automatic void chk(string nm, logic [63:0] got, logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", nm, got, exp);
    endfunction

    function automatic logic [39:0] rexp(logic pw, logic er, logic ec, logic rc, logic oe,
                                         logic [7:0] d, logic [26:0] a);
        return {pw, er, ec, rc, oe, d, a};
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        bus.cs = 1'b1; bus.cpu_addr = a; bus.cpu_data = d; bus.cpu_wr = 1'b1;
        tick(1);
        bus.cpu_wr = 1'b0; bus.cs = 1'b0;
    endtask

    task automatic rd(input logic [15:0] a, input logic [39:0] e, input string nm);
        exp_q.push_back(e);
        name_q.push_back(nm);
        bus.cs = 1'b1; bus.cpu_addr = a; bus.cpu_rd = 1'b1;
        tick(1);
        bus.cpu_rd = 1'b0; bus.cs = 1'b0;
    endtask

    task automatic unlock();
        wr(16'h4AAA, 8'hAA);
        wr(16'h4555, 8'h55);
    endtask

    task automatic do_reset(input int n);
        reset_n = 1'b0;
        tick(n);
        reset_n = 1'b1;
    endtask

    // Monitor: compare every observable DUT event against the expected queues
    always @(negedge clk) begin
        if (bus.cs && bus.cpu_rd) begin
            if (exp_q.size() == 0) chk("rd_unexpected", 64'd1, 64'd0);
            else chk($sformatf("rd_%s", name_q.pop_front()), 64'(bus_rd_word()), 64'(exp_q.pop_front()));
        end
        if (bus.prog_we) begin
            if (prog_q.size() == 0) chk("prog_unexpected", 64'd1, 64'd0);
            else chk("prog_pulse", 64'({bus.addr, bus.prog_data}), 64'(prog_q.pop_front()));
        end
        if (bus.erase_req && !er_prev) begin
            if (erase_q.size() == 0) chk("erase_unexpected", 64'd1, 64'd0);
            else begin
                logic [28:0] e;
                e = erase_q.pop_front();
                chk("erase_start", 64'({bus.erase_chip, e[28] ? bus.addr : 27'd0}), 64'(e[27:0]));
            end
        end
        if (done_prev) chk("erase_fall", 64'(bus.erase_req), 64'd0);
        er_prev   <= bus.erase_req;
        done_prev <= bus.erase_done && bus.erase_req && reset_n;
    end

    function automatic logic [39:0] bus_rd_word();
        return {bus.prog_we, bus.erase_req, bus.erase_chip, bus.ram_cs, bus.data_oe,
                bus.data, bus.addr};
    endfunction

    initial begin
        bus.cs = 1'b0; bus.cpu_addr = 16'h0; bus.cpu_data = 8'h0;
        bus.cpu_wr = 1'b0; bus.cpu_rd = 1'b0; bus.erase_done = 1'b0;
        reset_n = 1'b0;
        tick(3);
        reset_n = 1'b1;

        // reset bank map and out-of-window decode
        rd(16'h4000, rexp(0, 0, 0, 1, 0, 8'hFF, 27'h0000000), "win0");
        rd(16'h6000, rexp(0, 0, 0, 1, 0, 8'hFF, 27'h0002000), "win1");
        rd(16'h8000, rexp(0, 0, 0, 1, 0, 8'hFF, 27'h0004000), "win2");
        rd(16'hA000, rexp(0, 0, 0, 1, 0, 8'hFF, 27'h0006000), "win3");
        rd(16'h3000, rexp(0, 0, 0, 0, 0, 8'hFF, 27'h7FFFFFF), "below");
        rd(16'hC000, rexp(0, 0, 0, 0, 0, 8'hFF, 27'h7FFFFFF), "above");

        // bank write visible next cycle
        wr(16'h5000, 8'h12);
        rd(16'h4123, rexp(0, 0, 0, 1, 0, 8'hFF, 27'h0024123), "bank0_12");

        // byte program into bank 1, then status polling for 16 cycles
        do_reset(1);
        unlock();
        wr(16'h4AAA, 8'hA0);
        prog_q.push_back({27'h0002010, 8'h5A});
        wr(16'h6010, 8'h5A);
        tick(1);
        rd(16'h4000, rexp(0, 0, 0, 0, 1, 8'h80, 27'h0), "busy_c2");
        rd(16'h4000, rexp(0, 0, 0, 0, 1, 8'hC0, 27'h0), "busy_c3");
        tick(12);
        rd(16'h4000, rexp(0, 0, 0, 0, 1, 8'h80, 27'h0), "busy_c16");
        rd(16'h4000, rexp(0, 0, 0, 1, 0, 8'hFF, 27'h0), "busy_done");

        // sector erase of bank 7 through window 2; done collides with a write
        do_reset(1);
        wr(16'h9000, 8'h07);
        unlock();
        wr(16'h4AAA, 8'h80);
        unlock();
        erase_q.push_back({1'b1, 1'b0, 27'h000E000});
        wr(16'h8000, 8'h30);
        rd(16'h4000, rexp(0, 1, 0, 0, 1, 8'h00, 27'h000E000), "erase_c1");
        rd(16'h4000, rexp(0, 1, 0, 0, 1, 8'h40, 27'h000E000), "erase_c2");
        tick(3);
        bus.erase_done = 1'b1;
        wr(16'h9000, 8'h33);
        bus.erase_done = 1'b0;
        rd(16'h8000, rexp(0, 0, 0, 1, 0, 8'hFF, 27'h000E000), "after_erase");

        // autoselect, exit with F0, and a broken second unlock
        unlock();
        wr(16'h4AAA, 8'h90);
        rd(16'h4000, rexp(0, 0, 0, 0, 1, 8'h01, 27'h0), "manuf_id");
        rd(16'h4001, rexp(0, 0, 0, 0, 1, 8'hA4, 27'h1), "device_id");
        rd(16'h4002, rexp(0, 0, 0, 1, 0, 8'hFF, 27'h2), "auto_storage");
        wr(16'h4000, 8'hF0);
        rd(16'h4000, rexp(0, 0, 0, 1, 0, 8'hFF, 27'h0), "after_f0");
        wr(16'h4AAA, 8'hAA);
        wr(16'h4555, 8'h54);
        wr(16'h4AAA, 8'h90);
        rd(16'h4000, rexp(0, 0, 0, 1, 0, 8'hFF, 27'h0), "bad_unlock");

        // reset in the middle of a chip erase; a late erase_done is ignored
        unlock();
        wr(16'h4AAA, 8'h80);
        unlock();
        erase_q.push_back({1'b0, 1'b1, 27'h0});
        wr(16'h4AAA, 8'h10);
        tick(1);
        reset_n = 1'b0;
        tick(1);
        rd(16'h4000, rexp(0, 0, 0, 1, 0, 8'hFF, 27'h0), "rst_erase");
        reset_n = 1'b1;
        bus.erase_done = 1'b1;
        tick(1);
        bus.erase_done = 1'b0;
        rd(16'h6000, rexp(0, 0, 0, 1, 0, 8'hFF, 27'h2000), "late_done");

        // reset while a program is busy
        unlock();
        wr(16'h4AAA, 8'hA0);
        prog_q.push_back({27'h0000100, 8'h3C});
        wr(16'h4100, 8'h3C);
        tick(1);
        rd(16'h4000, rexp(0, 0, 0, 0, 1, 8'h80, 27'h0), "prog2_busy");
        reset_n = 1'b0;
        tick(1);
        rd(16'h4000, rexp(0, 0, 0, 1, 0, 8'hFF, 27'h0), "rst_prog");
        reset_n = 1'b1;
        tick(2);

        chk("rd_q_empty",    64'(exp_q.size()),   64'd0);
        chk("prog_q_empty",  64'(prog_q.size()),  64'd0);
        chk("erase_q_empty", 64'(erase_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
